scoreboard_hazard_unit: RTL and testbench

- Per-register scoreboard that generates the decode-stage `freeze` signal for the 5-stage ARM pipeline.
- Tracks, for every architectural register, how many cycles remain until a pending write-back makes its value visible to a register-file read in ID.
- Stalls the ID instruction while any source it reads, or a destination it would overwrite out of order, is still pending.
- Sits beside the decode stage: consumes decoded fields, drives `freeze` back into ID and into the IF/ID register enables.

---
 rtl/scoreboard_hazard_unit.sv | 89 ++++++++
 tb/tb_scoreboard_hazard_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_hazard_unit.sv
// Per-register write-back scoreboard producing the decode-stage freeze/issue pair.
// Optional macro SCOREBOARD_FORWARDING_EN: shorten latencies to load-use only (load 1, ALU 0).
module scoreboard_hazard_unit #(
  parameter int REG_COUNT  = 16,
  parameter int REG_ADDR_W = 4,
  parameter int ALU_LAT    = 2,
  parameter int MEM_LAT    = 3,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  cond_pass,
  input  logic                  flush,
  input  logic                  has_src1,
  input  logic                  has_src2,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic [REG_ADDR_W-1:0] dst,
  input  logic                  wb_en,
  input  logic                  mem_read,
  output logic                  freeze,
  output logic                  issue,
  output logic [REG_COUNT-1:0]  busy_mask,
  output logic [15:0]           stall_cycles
);

  logic [CNT_W-1:0]     r_cnt [REG_COUNT];
  logic [15:0]          r_stall_cycles;
  logic [REG_COUNT-1:0] w_busy;
  logic [CNT_W-1:0]     w_load_val;
  logic                 w_live;
  logic                 w_raw1;
  logic                 w_raw2;
  logic                 w_waw;
  logic                 w_freeze;
  logic                 w_issue;

`ifdef SCOREBOARD_FORWARDING_EN
  assign w_load_val = mem_read ? CNT_W'(1) : CNT_W'(0);
`else
  assign w_load_val = mem_read ? CNT_W'(MEM_LAT) : CNT_W'(ALU_LAT);
`endif

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      w_busy[i] = (r_cnt[i] != '0);
    end
  end

  // Handshake: id_valid offers the ID instruction; it is accepted (issue=1) in the
  // same cycle only when it is live (cond_pass, not flushed) and no hazard holds it.
  // freeze is the back-pressure; a bubble, failed condition or flush never freezes.
  // WAW stalls only while the older write would land after the new one.
  assign w_live   = id_valid & cond_pass & ~flush;
  assign w_raw1   = has_src1 & w_busy[src1];
  assign w_raw2   = has_src2 & w_busy[src2];
  assign w_waw    = wb_en & (r_cnt[dst] > w_load_val);
  assign w_freeze = w_live & (w_raw1 | w_raw2 | w_waw);
  assign w_issue  = w_live & ~w_freeze;

  // Reload on issue beats the countdown; self-dependence sees only the old count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_cnt[i] <= '0;
      end
      r_stall_cycles <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (w_issue && wb_en && (dst == REG_ADDR_W'(i))) begin
          r_cnt[i] <= w_load_val;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end
      end
      if (w_freeze && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
    end
  end

  assign freeze       = w_freeze;
  assign issue        = w_issue;
  assign busy_mask    = w_busy;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench for scoreboard_hazard_unit; expected freeze/issue pairs are
// queued as stimulus is planned and popped as each cycle is sampled.
module tb_scoreboard_hazard_unit;

`ifdef SCOREBOARD_FORWARDING_EN
  localparam int ALU_L = 0;
  localparam int MEM_L = 1;
  localparam int SAT_L = 1;
`else
  localparam int ALU_L = 2;
  localparam int MEM_L = 3;
  localparam int SAT_L = 7;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic        cond_pass = 1'b0;
  logic        flush = 1'b0;
  logic        has_src1 = 1'b0;
  logic        has_src2 = 1'b0;
  logic [3:0]  src1 = '0;
  logic [3:0]  src2 = '0;
  logic [3:0]  dst = '0;
  logic        wb_en = 1'b0;
  logic        mem_read = 1'b0;
  logic        freeze;
  logic        issue;
  logic [15:0] busy_mask;
  logic [15:0] stall_cycles;

  logic        s_rst = 1'b1;
  logic        s_freeze;
  logic        s_issue;
  logic [15:0] s_busy;
  logic [15:0] s_stall;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  exp_q[$];

  always #5 clk = ~clk;

  scoreboard_hazard_unit u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .cond_pass(cond_pass), .flush(flush),
    .has_src1(has_src1), .has_src2(has_src2), .src1(src1), .src2(src2), .dst(dst),
    .wb_en(wb_en), .mem_read(mem_read), .freeze(freeze), .issue(issue),
    .busy_mask(busy_mask), .stall_cycles(stall_cycles)
  );

  // Second instance with the longest load latency: a self-dependent load held in ID.
  scoreboard_hazard_unit #(.MEM_LAT(7)) u_sat (
    .clk(clk), .rst(s_rst), .id_valid(1'b1), .cond_pass(1'b1), .flush(1'b0),
    .has_src1(1'b1), .has_src2(1'b0), .src1(4'd3), .src2(4'd0), .dst(4'd3),
    .wb_en(1'b1), .mem_read(1'b1), .freeze(s_freeze), .issue(s_issue),
    .busy_mask(s_busy), .stall_cycles(s_stall)
  );

  typedef struct {
    logic v, cp, fl, h1;
    logic [3:0] s1, d;
    logic wb, mr;
  } stim_t;

  task automatic drive_id(input logic v, input logic cp, input logic fl,
                          input logic h1, input logic h2,
                          input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                          input logic wb, input logic mr);
    @(negedge clk);
    id_valid = v; cond_pass = cp; flush = fl;
    has_src1 = h1; has_src2 = h2; src1 = s1; src2 = s2; dst = d;
    wb_en = wb; mem_read = mr;
    #1;
  endtask

  task automatic idle();
    drive_id(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    id_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int sat_expect(input int n);
    int issues;
    int stalls;
    issues = (n + SAT_L) / (SAT_L + 1);
    stalls = n - issues;
    return (stalls > 65535) ? 65535 : stalls;
  endfunction

  task automatic test_reset();
    do_reset();
    idle();
    checks++;
    if ({freeze, issue} !== 2'b00) begin
      errors++; $display("FAIL reset_fi got=%b exp=00", {freeze, issue});
    end
    checks++;
    if (busy_mask !== 16'h0000) begin
      errors++; $display("FAIL reset_busy got=%h exp=0000", busy_mask);
    end
    checks++;
    if (stall_cycles !== 16'h0000) begin
      errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles);
    end
    drive_id(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 4'd4, 4'd3, 1'b1, 1'b0);
    checks++;
    if ({freeze, issue} !== 2'b01) begin
      errors++; $display("FAIL reset_first_issue got=%b exp=01", {freeze, issue});
    end
    repeat (8) idle();
  endtask

  task automatic test_alu_raw();
    logic [1:0] exp;
    int k;
    do_reset();
    drive_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0);
    checks++;
    if ({freeze, issue} !== 2'b01) begin
      errors++; $display("FAIL alu_writer got=%b exp=01", {freeze, issue});
    end
    for (int i = 0; i <= ALU_L; i++) exp_q.push_back((i < ALU_L) ? 2'b10 : 2'b01);
    k = 0;
    while (exp_q.size() > 0) begin
      drive_id(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 4'd6, 1'b1, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if ({freeze, issue} !== exp) begin
        errors++; $display("FAIL alu_raw cyc=%0d got=%b exp=%b", k, {freeze, issue}, exp);
      end
      k++;
    end
    idle();
    checks++;
    if (stall_cycles !== 16'(ALU_L)) begin
      errors++; $display("FAIL alu_raw_stalls got=%0d exp=%0d", stall_cycles, ALU_L);
    end
    repeat (8) idle();
  endtask

  task automatic test_load_use();
    logic [1:0] exp;
    int k;
    do_reset();
    drive_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1);
    checks++;
    if ({freeze, issue} !== 2'b01) begin
      errors++; $display("FAIL load_writer got=%b exp=01", {freeze, issue});
    end
    for (int i = 0; i <= MEM_L; i++) exp_q.push_back((i < MEM_L) ? 2'b10 : 2'b01);
    k = 0;
    while (exp_q.size() > 0) begin
      drive_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if ({freeze, issue} !== exp) begin
        errors++; $display("FAIL load_use cyc=%0d got=%b exp=%b", k, {freeze, issue}, exp);
      end
      checks++;
      if (busy_mask[5] !== (k < MEM_L)) begin
        errors++; $display("FAIL load_busy5 cyc=%0d got=%b exp=%b", k, busy_mask[5], (k < MEM_L));
      end
      k++;
    end
    idle();
    checks++;
    if (stall_cycles !== 16'(MEM_L)) begin
      errors++; $display("FAIL load_use_stalls got=%0d exp=%0d", stall_cycles, MEM_L);
    end
    repeat (8) idle();
  endtask

  task automatic test_no_stall();
    stim_t tbl[8];
    logic [1:0] exp;
    do_reset();
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 1'b1}; // LDR r3
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd9, 1'b0, 1'b0}; // names r3, has_src1=0
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 1'b1}; // LDR r3 again
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd9, 1'b0, 1'b0}; // cond failed
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 4'd9, 1'b0, 1'b0}; // flushed
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 4'd9, 1'b0, 1'b0}; // real dependent
    exp_q = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 8; i++) begin
      drive_id(tbl[i].v, tbl[i].cp, tbl[i].fl, tbl[i].h1, 1'b0, tbl[i].s1, 4'd0,
               tbl[i].d, tbl[i].wb, tbl[i].mr);
      exp = exp_q.pop_front();
      checks++;
      if ({freeze, issue} !== exp) begin
        errors++; $display("FAIL no_stall step=%0d got=%b exp=%b", i, {freeze, issue}, exp);
      end
    end
    repeat (8) idle();
  endtask

  task automatic test_waw();
    logic [1:0] exp;
    int k;
    do_reset();
    drive_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 1'b1, 1'b1);
    for (int i = 0; i <= MEM_L - ALU_L; i++)
      exp_q.push_back((i < MEM_L - ALU_L) ? 2'b10 : 2'b01);
    k = 0;
    while (exp_q.size() > 0) begin
      drive_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if ({freeze, issue} !== exp) begin
        errors++; $display("FAIL waw cyc=%0d got=%b exp=%b", k, {freeze, issue}, exp);
      end
      k++;
    end
    for (int i = 0; i <= ALU_L; i++) begin
      idle();
      checks++;
      if (busy_mask[2] !== (i < ALU_L)) begin
        errors++; $display("FAIL waw_reload cyc=%0d got=%b exp=%b", i, busy_mask[2], (i < ALU_L));
      end
    end
    repeat (8) idle();
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp_mask;
    do_reset();
    drive_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1);
    drive_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd4, 1'b1, 1'b1);
    drive_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1);
    drive_id(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0);
    exp_mask = '0;
    exp_mask[1] = (MEM_L - 2 > 0);
    exp_mask[4] = (MEM_L - 1 > 0);
    exp_mask[7] = (MEM_L > 0);
    checks++;
    if (busy_mask !== exp_mask) begin
      errors++; $display("FAIL mid_busy_before got=%h exp=%h", busy_mask, exp_mask);
    end
    checks++;
    if ({freeze, issue} !== 2'b10) begin
      errors++; $display("FAIL mid_dep_before got=%b exp=10", {freeze, issue});
    end
    idle();
    checks++;
    if (stall_cycles !== 16'd1) begin
      errors++; $display("FAIL mid_stall_before got=%0d exp=1", stall_cycles);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive_id(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0);
    checks++;
    if (busy_mask !== 16'h0000) begin
      errors++; $display("FAIL mid_busy_after got=%h exp=0000", busy_mask);
    end
    checks++;
    if (stall_cycles !== 16'h0000) begin
      errors++; $display("FAIL mid_stall_after got=%0d exp=0", stall_cycles);
    end
    checks++;
    if ({freeze, issue} !== 2'b01) begin
      errors++; $display("FAIL mid_dep_after got=%b exp=01", {freeze, issue});
    end
    repeat (8) idle();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    logic [3:0] a, b;
    logic mra, mrb, via2;
    int la, st, k;
    do_reset();
    repeat (6) begin
      a    = 4'($urandom_range(1, 15));
      b    = (a == 4'd15) ? 4'd1 : a + 4'd1;
      mra  = 1'($urandom_range(0, 1));
      mrb  = 1'($urandom_range(0, 1));
      via2 = 1'($urandom_range(0, 1));
      la   = mra ? MEM_L : ALU_L;
      st   = (la > 1) ? la - 1 : 0;
      drive_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, a, 1'b1, mra);
      drive_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, b, 1'b1, mrb);
      checks++;
      if ({freeze, issue} !== 2'b01) begin
        errors++; $display("FAIL b2b_writer reg=%0d got=%b exp=01", b, {freeze, issue});
      end
      for (int i = 0; i <= st; i++) exp_q.push_back((i < st) ? 2'b10 : 2'b01);
      k = 0;
      while (exp_q.size() > 0) begin
        drive_id(1'b1, 1'b1, 1'b0, ~via2, via2, a, a, 4'd0, 1'b0, 1'b0);
        exp = exp_q.pop_front();
        checks++;
        if ({freeze, issue} !== exp) begin
          errors++;
          $display("FAIL b2b_dep reg=%0d mr=%b cyc=%0d got=%b exp=%b", a, mra, k, {freeze, issue}, exp);
        end
        k++;
      end
      repeat (8) idle();
    end
  endtask

  task automatic test_saturation();
    int exp;
    @(negedge clk);
    s_rst = 1'b0;
    repeat (8000) @(posedge clk);
    @(negedge clk);
    exp = sat_expect(8000);
    checks++;
    if (s_stall !== 16'(exp)) begin
      errors++; $display("FAIL sat_partial got=%0d exp=%0d", s_stall, exp);
    end
    repeat (67000) @(posedge clk);
    @(negedge clk);
    exp = sat_expect(75000);
    checks++;
    if (s_stall !== 16'(exp)) begin
      errors++; $display("FAIL sat_final got=%0d exp=%0d", s_stall, exp);
    end
  endtask

  initial begin
    test_reset();
    test_alu_raw();
    test_load_use();
    test_no_stall();
    test_waw();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
